pipeline_width_upsizer: RTL and testbench
=========================================

Name: pipeline_width_upsizer

Overview:
- Downstream stage that consumes the narrow valid/ready stream from a single-stage pipeline register.
- Packs RATIO consecutive DATA_WIDTH beats into one wide word, lane 0 first.
- Emits each packed word on a registered valid/ready output.
- input_last flushes a partial word early; out_keep marks which lanes are populated.

Parameters:
- DATA_WIDTH, 8, width of one input beat.
- RATIO, 4, beats per output word; must be at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- input_data  input  DATA_WIDTH  narrow beat.
- input_valid  input  1  beat present.
- input_last  input  1  final beat of a packet; qualified by input_valid.
- input_ready  output  1  block accepts the beat this cycle.
- out_data  output  DATA_WIDTH*RATIO  packed word; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_keep  output  RATIO  lane-valid mask; bit i set means lane i holds data.
- out_valid  output  1  packed word present.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Clock and reset: one clock (clk). reset_n is asynchronous assert, active-low.
- Reset values:
  - out_valid=0, out_data=0, out_keep=0.
  - Internal beat counter=0; accumulation register=0; accumulation keep=0.
- input_ready is combinational: reset_n && (!out_valid || out_ready). It is 0 while reset_n is low. It never depends on input_valid or input_last.
- Accept: input_valid && input_ready at a rising edge.
- Non-completing accept (cnt < RATIO-1 and input_last=0):
  - Beat is written to lane cnt of the accumulation register.
  - Keep bit cnt is set; cnt increments.
  - Output register is not touched.
- Completing accept (cnt == RATIO-1, or input_last=1):
  - out_data <= accumulation with the beat inserted at lane cnt; lanes above cnt are zero.
  - out_keep <= bits 0..cnt set; out_valid <= 1.
  - Accumulation register, keep and cnt are all cleared.
- Latency: out_valid rises 1 cycle after the completing beat is accepted.
- Drain: out_valid && out_ready with no completing accept in the same cycle gives out_valid <= 0. out_data and out_keep hold their values.
- Simultaneous drain and completing accept: the new word loads and out_valid stays 1. There is no bubble, so full throughput is RATIO input beats per output word.
- Stall: while out_valid && !out_ready, out_data and out_keep are stable and input_ready=0. Accumulation is frozen.
- input_last on an accept at cnt=0: one-lane word, out_keep=0001 (RATIO=4).
- input_last on the beat at cnt=RATIO-1 behaves as a normal full word; keep is all ones.
- Counter wraps to 0 after every completing accept and never exceeds RATIO-1.
- Reset mid-operation:
  - Any partial accumulation and any pending output are discarded.
  - out_valid drops asynchronously.
  - The first accept after release lands in lane 0.
- No separate FSM. State is {cnt, output-register-full}, and both update only on the events above.

Decomposition:
- Shared package pipe_pkg holds:
  - helper function lane_mask(cnt) returning the RATIO-bit keep for lanes 0..cnt;
  - the localparam for counter width, $clog2(RATIO).
- No sub-module: accumulation register, counter and output register live in one module.
- Lane insertion is an indexed part-select write.

Test Plan:
All scenarios use DATA_WIDTH=8 and RATIO=4.
1. Hold reset_n=0 for 20 ns with input_valid=1 -> out_valid=0, input_ready=0, out_data=0x00000000. After release, the first accepted beat lands in lane 0.
2. Full word: beats 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 -> one cycle after the 4th accept, out_valid=1, out_data=0x44332211, out_keep=4'b1111.
3. Partial flush: 0xAA, then 0xBB with input_last=1 -> out_data=0x0000BBAA, out_keep=4'b0011. The next word starts at lane 0.
4. Stall: word 0x44332211 pending with out_ready=0 for 3 cycles -> input_ready=0 and out_data stable. Raise out_ready -> word consumed; input_ready=1 the same cycle.
5. Back-to-back: 8 continuous beats 0x01..0x08 with out_ready=1 -> words 0x04030201 then 0x08070605. input_ready stays 1 throughout, with no idle cycle between words.
6. Reset mid-word: accept 0x01,0x02, pulse reset_n low, then send 0x0A,0x0B,0x0C,0x0D -> out_data=0x0D0C0B0A, out_keep=4'b1111. 0x01 and 0x02 never appear.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the narrow-to-wide stream packer.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_WIDTH = 8;
    localparam int unsigned PIPE_RATIO      = 4;
    localparam int unsigned PIPE_CNT_WIDTH  = $clog2(PIPE_RATIO);

    // Keep mask with lanes 0..cnt set; callers truncate to their lane count.
    function automatic logic [31:0] lane_mask(input logic [31:0] cnt);
        logic [32:0] m;
        m = (33'd2 << cnt) - 33'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/pipeline_width_upsizer.sv
// Packs RATIO narrow beats (lane 0 first) into one registered wide word.
module pipeline_width_upsizer
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int unsigned RATIO      = PIPE_RATIO
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_WIDTH-1:0]         input_data,
    input  logic                          input_valid,
    input  logic                          input_last,
    output logic                          input_ready,
    output logic [DATA_WIDTH*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]              out_keep,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int unsigned WORD_WIDTH = DATA_WIDTH * RATIO;
    localparam int unsigned CNT_WIDTH  = $clog2(RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

    logic [CNT_WIDTH-1:0]  cnt;
    logic [WORD_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]      acc_keep;
    logic [WORD_WIDTH-1:0] ins_data;
    logic [RATIO-1:0]      ins_keep;
    logic                  accept;
    logic                  completing;

    // Ready whenever the output slot is empty or being drained this cycle.
    assign input_ready = reset_n && (!out_valid || out_ready);
    assign accept      = input_valid && input_ready;
    assign completing  = (cnt == LAST_LANE) || input_last;

    // Accumulation with the current beat dropped into lane cnt.
    always_comb begin
        ins_data = acc_data;
        ins_data[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] = input_data;
        ins_keep = acc_keep | RATIO'(lane_mask(32'(cnt)));
    end

    // Lane counter, accumulation register and output word register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            acc_data  <= '0;
            acc_keep  <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (accept && completing) begin
            out_data  <= ins_data;
            out_keep  <= ins_keep;
            out_valid <= 1'b1;
            cnt       <= '0;
            acc_data  <= '0;
            acc_keep  <= '0;
        end else begin
            if (accept) begin
                acc_data <= ins_data;
                acc_keep <= ins_keep;
                cnt      <= cnt + CNT_WIDTH'(1);
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_width_upsizer.sv
// Directed checks for pipeline_width_upsizer with DATA_WIDTH=8, RATIO=4.
module tb_pipeline_width_upsizer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  input_data;
    logic        input_valid;
    logic        input_last;
    logic        input_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;

    int n_vec;
    int n_err;

    pipeline_width_upsizer #(
        .DATA_WIDTH(8),
        .RATIO     (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .input_data (input_data),
        .input_valid(input_valid),
        .input_last (input_last),
        .input_ready(input_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat, confirm it is accepted at the next edge, then withdraw it.
    task automatic beat(input logic [7:0] d, input logic last);
        input_valid = 1'b1;
        input_data  = d;
        input_last  = last;
        #1;
        check("beat_ready", 32'(input_ready), 32'd1);
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        input_valid = 1'b1;
        input_data  = 8'h55;
        input_last  = 1'b0;
        out_ready   = 1'b1;

        // 1: reset held with a beat offered
        #20;
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_input_ready", 32'(input_ready), 32'd0);
        check("rst_out_data",    out_data,         32'h00000000);
        check("rst_out_keep",    32'(out_keep),    32'd0);
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        reset_n     = 1'b1;
        #1;
        check("rel_input_ready", 32'(input_ready), 32'd1);
        beat(8'h5A, 1'b1);
        check("first_lane0_data", out_data,      32'h0000005A);
        check("first_lane0_keep", 32'(out_keep), 32'h1);
        idle_cycle();
        check("first_drained", 32'(out_valid), 32'd0);

        // 2: full word
        beat(8'h11, 1'b0);
        check("full_not_yet", 32'(out_valid), 32'd0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        check("full_not_yet3", 32'(out_valid), 32'd0);
        beat(8'h44, 1'b0);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_data",  out_data,        32'h44332211);
        check("full_keep",  32'(out_keep),   32'hF);
        idle_cycle();
        check("full_drain_valid", 32'(out_valid), 32'd0);
        check("full_drain_hold",  out_data,        32'h44332211);

        // 3: partial flush, then next word starts at lane 0
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        check("part_valid", 32'(out_valid), 32'd1);
        check("part_data",  out_data,        32'h0000BBAA);
        check("part_keep",  32'(out_keep),   32'h3);
        idle_cycle();
        beat(8'hCC, 1'b1);
        check("part_next_data", out_data,      32'h000000CC);
        check("part_next_keep", 32'(out_keep), 32'h1);
        idle_cycle();

        // 4: stall with a beat offered, then release
        out_ready = 1'b0;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        input_valid = 1'b1;
        input_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("stall_ready", 32'(input_ready), 32'd0);
            check("stall_valid", 32'(out_valid),   32'd1);
            check("stall_data",  out_data,          32'h44332211);
            check("stall_keep",  32'(out_keep),     32'hF);
        end
        input_valid = 1'b0;
        out_ready   = 1'b1;
        #1;
        check("unstall_ready", 32'(input_ready), 32'd1);
        idle_cycle();
        check("unstall_drained", 32'(out_valid), 32'd0);
        beat(8'h77, 1'b1);
        check("stall_no_leak_data", out_data,      32'h00000077);
        check("stall_no_leak_keep", 32'(out_keep), 32'h1);
        idle_cycle();

        // 5: eight back-to-back beats
        for (int i = 1; i <= 4; i++) beat(8'(i), 1'b0);
        check("b2b_w0_valid", 32'(out_valid), 32'd1);
        check("b2b_w0_data",  out_data,        32'h04030201);
        for (int i = 5; i <= 8; i++) beat(8'(i), 1'b0);
        check("b2b_w1_valid", 32'(out_valid), 32'd1);
        check("b2b_w1_data",  out_data,        32'h08070605);
        check("b2b_w1_keep",  32'(out_keep),   32'hF);
        idle_cycle();

        // 6a: pending word dropped asynchronously by reset
        out_ready = 1'b0;
        beat(8'hE1, 1'b1);
        check("pend_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_data",  out_data,        32'h00000000);
        check("async_ready", 32'(input_ready), 32'd0);
        idle_cycle();
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // 6b: partial word discarded by reset
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        reset_n = 1'b0;
        idle_cycle();
        reset_n = 1'b1;
        beat(8'h0A, 1'b0);
        beat(8'h0B, 1'b0);
        beat(8'h0C, 1'b0);
        beat(8'h0D, 1'b0);
        check("rstmid_valid", 32'(out_valid), 32'd1);
        check("rstmid_data",  out_data,        32'h0D0C0B0A);
        check("rstmid_keep",  32'(out_keep),   32'hF);
        idle_cycle();
        check("end_drained", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
